// File: rtl/mem_arbiter.sv
// mem_arbiter
// ----------------------------------------------------------------------------
// Shares the single unified instruction/data memory of cpu_top between the
// fetch stage (instruction reads) and the memory stage (loads/stores). One
// access is in flight at a time. When both requesters ask in the same cycle,
// the data port wins.
//
// Optional feature: define ARB_STARVE_GUARD_EN to enable the fetch starvation
// guard. With it, after STARVE_MAX consecutive data grants taken while fetch
// was waiting, the next grant goes to fetch. Without it, data priority is
// strict and STARVE_MAX has no effect.
//
// Handshake (both requester ports): the requester raises req together with
// its address/controls and holds them stable until the one-cycle ready pulse.
// The ready cycle is an ordinary IDLE cycle. A requester that keeps req high
// during that cycle, with a new address, is treated as issuing a new request.
// Read data stays on if_rdata/dm_rdata until the next read on that port
// completes.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   if_req/if_addr        fetch request and address
//   if_rdata/if_ready     fetched word and its completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata   data request (we=1 store, we=0 load)
//   dm_rdata/dm_ready     load data and its completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory macro side
//   busy                  high while an access is in ISSUE or WAIT
//   grant_if              1 when the current/last grant went to fetch
//
// FSM visibility: IDLE is busy=0; ISSUE is mem_en=1; WAIT is busy=1 with
// mem_en=0.
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          grant_if_q, grant_if_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          dm_ready_q, dm_ready_d;

    // force_if: fetch must win the next grant even if data is requesting.
    logic          force_if;
    logic          pick_if;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Counts data grants taken while fetch was waiting; cleared by any fetch
    // grant. It cannot pass STARVE_MAX because reaching it with fetch
    // waiting forces the next grant to fetch.
    logic [SW-1:0] starve_q, starve_d;

    assign force_if = if_req && (starve_q == SW'(STARVE_MAX));
`else
    logic unused_starve_max;

    assign force_if          = 1'b0;
    assign unused_starve_max = ^STARVE_MAX;
`endif

    assign pick_if = force_if || !dm_req;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        grant_if_d  = grant_if_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        starve_d    = starve_q;
`endif

        case (state_q)
            IDLE: begin
                if (dm_req || if_req) begin
                    state_d = ISSUE;
                    if (pick_if) begin
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        grant_if_d  = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
                        starve_d    = '0;
`endif
                    end else begin
                        mem_addr_d  = dm_addr;
                        mem_we_d    = dm_we;
                        mem_wdata_d = dm_wdata;
                        grant_if_d  = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
                        if (if_req) begin
                            starve_d = starve_q + 1'b1;
                        end
`endif
                    end
                end
            end

            ISSUE: begin
                cnt_d   = 4'(MEM_LAT);
                state_d = WAIT;
            end

            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // The counter reaches 0 on this edge: memory data is valid now.
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    if (grant_if_q) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                        dm_ready_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            grant_if_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            grant_if_q  <= grant_if_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_if  = grant_if_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// ----------------------------------------------------------------------------
// Bench for mem_arbiter (MEM_LAT=3, STARVE_MAX=4); honours ARB_STARVE_GUARD_EN
// when it is defined for the build.
//
// The reference model works on access slots. Once the arbiter is free, the
// first edge with any request starts an access, and the spec's priority rule
// picks the winner. mem_en, ready and busy then follow at fixed offsets from
// that edge, and the arbiter is free again MEM_LAT+2 edges later.
//
// Expected read data is queued per port at issue time:
//   - fetches read a read-only region (init_val);
//   - the data port keeps a shadow memory in program order;
//   - a store expects dm_rdata to still hold the last load value.
// A monitor on the falling edge pops the queues whenever a ready pulse
// appears.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LAT   = 3;
    localparam int SMAX  = 4;
    localparam int BOUND = 400;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          if_req   = 1'b0;
    logic [AW-1:0] if_addr  = '0;
    logic          dm_req   = 1'b0;
    logic          dm_we    = 1'b0;
    logic [AW-1:0] dm_addr  = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          if_ready, dm_ready, mem_en, mem_we, busy, grant_if;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    mem_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .MEM_LAT   (LAT),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .grant_if (grant_if)
    );

    // ---------------- compare helpers ----------------
    task automatic check_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Initial memory contents; address 0 holds 0x00500093.
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00500093;
    endfunction

    // ---------------- memory model (fixed latency LAT) ----------------
    logic [31:0] mem_arr [logic [31:0]];
    int          mcnt  = 0;
    logic [31:0] mdata = '0;

    assign mem_rdata = (mcnt == 1) ? mdata : 32'hBAD0BAD0;

    initial begin
        logic        s_en, s_we;
        logic [31:0] s_addr, s_wd;
        forever begin
            @(negedge clk);
            s_en   = mem_en;
            s_we   = mem_we;
            s_addr = mem_addr;
            s_wd   = mem_wdata;
            @(posedge clk);
            if (mcnt > 0) mcnt <= mcnt - 1;
            if (s_en) begin
                if (s_we) begin
                    mem_arr[s_addr] = s_wd;
                end else begin
                    mdata <= mem_arr.exists(s_addr) ? mem_arr[s_addr] : init_val(s_addr);
                end
                mcnt <= LAT;
            end
        end
    end

    // ---------------- reference model (access slots) ----------------
    int          cyc       = 0;
    int          free_cyc  = 0;
    int          en_at     = -1;
    int          rdy_at    = -1;
    int          scnt      = 0;
    bit          cur_valid = 1'b0;
    bit          cur_f     = 1'b0;
    bit          cur_we    = 1'b0;
    bit          model_gf  = 1'b0;
    logic [31:0] cur_addr  = '0;
    logic [31:0] cur_wdata = '0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                cur_valid = 1'b0;
                model_gf  = 1'b0;
                scnt      = 0;
                free_cyc  = 0;
            end else begin
                cyc++;
                if (cyc >= free_cyc && (dm_req || if_req)) begin
                    bit take_f;
`ifdef ARB_STARVE_GUARD_EN
                    take_f = !dm_req || (if_req && scnt == SMAX);
`else
                    take_f = !dm_req;
`endif
                    if (take_f) scnt = 0;
                    else if (if_req) scnt++;
                    cur_valid = 1'b1;
                    cur_f     = take_f;
                    model_gf  = take_f;
                    cur_addr  = take_f ? if_addr : dm_addr;
                    cur_we    = take_f ? 1'b0 : dm_we;
                    cur_wdata = dm_wdata;
                    en_at     = cyc;
                    rdy_at    = cyc + LAT + 1;
                    free_cyc  = cyc + LAT + 2;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] if_exp_q[$];
    logic [DW-1:0] dm_exp_q[$];
    bit            grant_log[$];
    logic [DW-1:0] last_load = '0;
    logic [DW-1:0] shadow [logic [31:0]];

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                bit e_en, e_busy, e_ifr, e_dmr;
                e_en   = cur_valid && (cyc == en_at);
                e_busy = cur_valid && (cyc >= en_at) && (cyc < rdy_at);
                e_ifr  = cur_valid && (cyc == rdy_at) && cur_f;
                e_dmr  = cur_valid && (cyc == rdy_at) && !cur_f;
                check_b("mem_en", mem_en, e_en);
                check_b("busy", busy, e_busy);
                check_b("if_ready", if_ready, e_ifr);
                check_b("dm_ready", dm_ready, e_dmr);
                check_b("grant_if", grant_if, model_gf);
                check_b("ready_overlap", if_ready && dm_ready, 1'b0);
                if (mem_en) begin
                    grant_log.push_back(grant_if);
                    if (e_en) begin
                        check_w("mem_addr", mem_addr, cur_addr);
                        check_b("mem_we", mem_we, cur_we);
                        if (cur_we) check_w("mem_wdata", mem_wdata, cur_wdata);
                    end
                end
                if (if_ready) begin
                    check_b("if_exp_pending", if_exp_q.size() != 0, 1'b1);
                    if (if_exp_q.size() != 0) check_w("if_rdata", if_rdata, if_exp_q.pop_front());
                end
                if (dm_ready) begin
                    check_b("dm_exp_pending", dm_exp_q.size() != 0, 1'b1);
                    if (dm_exp_q.size() != 0) check_w("dm_rdata", dm_rdata, dm_exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Called #1 after a rising edge. Returns the number of edges until ready
    // is seen, counting the edge that samples the request.
    task automatic fetch_txn(input logic [31:0] a, input logic keep, output int n);
        if_req  = 1'b1;
        if_addr = a;
        if_exp_q.push_back(init_val(a));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!if_ready && n < BOUND);
        check_b("if_handshake", if_ready, 1'b1);
        if (!keep || !if_ready) if_req = 1'b0;
    endtask

    task automatic dm_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic keep, output int n);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        if (we) begin
            shadow[a] = wd;
        end else begin
            last_load = shadow.exists(a) ? shadow[a] : init_val(a);
        end
        dm_exp_q.push_back(last_load);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!dm_ready && n < BOUND);
        check_b("dm_handshake", dm_ready, 1'b1);
        if (!keep || !dm_ready) dm_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_b({tag, "_mem_en"}, mem_en, 1'b0);
        check_b({tag, "_mem_we"}, mem_we, 1'b0);
        check_b({tag, "_busy"}, busy, 1'b0);
        check_b({tag, "_if_ready"}, if_ready, 1'b0);
        check_b({tag, "_dm_ready"}, dm_ready, 1'b0);
        check_b({tag, "_grant_if"}, grant_if, 1'b0);
        check_w({tag, "_mem_addr"}, mem_addr, 32'h0);
        check_w({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check_w({tag, "_if_rdata"}, if_rdata, 32'h0);
        check_w({tag, "_dm_rdata"}, dm_rdata, 32'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int n, nd, nf;
        bit exp_f;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // First fetch from address 0.
        fetch_txn(32'h0, 1'b0, n);
        check_i("first_fetch_latency", n, LAT + 2);
        check_w("first_fetch_data", if_rdata, 32'h00500093);

        // Store, then load the same address.
        dm_txn(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, n);
        check_i("store_latency", n, LAT + 2);
        check_w("store_keeps_dm_rdata", dm_rdata, 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        dm_txn(1'b0, 32'h100, 32'h0, 1'b0, n);
        check_w("load_after_store", dm_rdata, 32'hDEADBEEF);

        // Both ports in the same cycle: data first, fetch one access later.
        fork
            dm_txn(1'b0, 32'h104, 32'h0, 1'b0, nd);
            fetch_txn(32'h10, 1'b0, nf);
        join
        check_i("simul_data_latency", nd, LAT + 2);
        check_i("simul_fetch_latency", nf, 2 * LAT + 4);

        // Both held continuously: grant order depends on the starvation guard.
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    dm_txn(1'b0, 32'h104 + 32'(4 * (i % 4)), 32'h0, 1'(i < 9), nd);
            end
            begin
                for (int j = 0; j < 3; j++)
                    fetch_txn(32'h20 + 32'(4 * j), 1'(j < 2), nf);
            end
        join
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_f = ((k % 5) == 4);
`else
            exp_f = 1'b0;
`endif
            if (k < grant_log.size()) check_b($sformatf("starve_grant_%0d", k), grant_log[k], exp_f);
            else check_i("starve_grant_count", grant_log.size(), 10);
        end

        // Back-to-back fetches: one ready every LAT+2 cycles.
        fetch_txn(32'h0, 1'b1, n);
        check_i("b2b_fetch0", n, LAT + 2);
        fetch_txn(32'h4, 1'b1, n);
        check_i("b2b_fetch1", n, LAT + 2);
        fetch_txn(32'h8, 1'b0, n);
        check_i("b2b_fetch2", n, LAT + 2);

        // Reset asserted while in WAIT.
        if_req  = 1'b1;
        if_addr = 32'h30;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(busy && !mem_en) && n < BOUND);
        check_b("reached_wait", busy && !mem_en, 1'b1);
        reset  = 1'b1;
        if_req = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        reset     = 1'b0;
        last_load = '0;
        fetch_txn(32'h34, 1'b0, n);
        check_i("post_reset_latency", n, LAT + 2);

        // Randomized traffic on both ports.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    dm_txn(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 15)),
                           $urandom, (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0, nd);
                    if (!dm_req) begin
                        repeat ($urandom_range(0, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    fetch_txn(32'(4 * $urandom_range(0, 63)),
                              (j < 39) ? 1'($urandom_range(0, 1)) : 1'b0, nf);
                    if (!if_req) begin
                        repeat ($urandom_range(0, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
            end
        join

        repeat (10) @(posedge clk);
        #1;
        check_i("if_exp_drained", if_exp_q.size(), 0);
        check_i("dm_exp_drained", dm_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
